// File: rtl/vk_axi_pkg.sv
// Shared definitions for the vector-search AXI-Lite read responder:
// register map, memory window, response codes, FSM encoding and address decode.
package vk_axi_pkg;

    localparam logic [15:0] REG_STATUS = 16'h0000;
    localparam logic [15:0] REG_WINNER = 16'h0004;
    localparam logic [15:0] REG_SCORE  = 16'h0008;
    localparam logic [15:0] REG_CYCLES = 16'h000C;

    // Vector memory window 0x2000-0x3FFF: the top three offset bits equal 3'b001
    localparam logic [15:0] MEM_BASE = 16'h2000;
    localparam logic [15:0] MEM_MASK = 16'hE000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP     = 2'd2;

    typedef enum logic [2:0] {
        DEC_STATUS,
        DEC_WINNER,
        DEC_SCORE,
        DEC_CYCLES,
        DEC_MEM,
        DEC_BAD
    } dec_e;

    // Classify a 16-bit read offset; register offsets must match exactly
    function automatic dec_e decode_addr(input logic [15:0] a);
        dec_e d;
        d = DEC_BAD;
        if ((a & MEM_MASK) == MEM_BASE) begin
            d = DEC_MEM;
        end else begin
            case (a)
                REG_STATUS: d = DEC_STATUS;
                REG_WINNER: d = DEC_WINNER;
                REG_SCORE:  d = DEC_SCORE;
                REG_CYCLES: d = DEC_CYCLES;
                default:    d = DEC_BAD;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/vk_search_tracker.sv
// Watches the search core's busy line: counts busy cycles and snapshots the
// result on the falling edge. done is sticky until a STATUS read clears it.
module vk_search_tracker
    import vk_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        busy,
    input  logic [7:0]  winner_id,
    input  logic [31:0] max_score,
    input  logic        clr_done,
    output logic        done,
    output logic [7:0]  winner_sh,
    output logic [31:0] score_sh,
    output logic [31:0] cycles_sh
);

    logic        busy_q,   busy_d;
    logic [31:0] counter_q, counter_d;
    logic        done_q,   done_d;
    logic [7:0]  winner_q, winner_d;
    logic [31:0] score_q,  score_d;
    logic [31:0] cycles_q, cycles_d;
    logic        rise, fall;

    assign rise = busy & ~busy_q;
    assign fall = ~busy & busy_q;

    // Edge detection, saturating cycle count and shadow capture; a fall beats a clear
    always_comb begin
        busy_d    = busy;
        counter_d = counter_q;
        done_d    = done_q;
        winner_d  = winner_q;
        score_d   = score_q;
        cycles_d  = cycles_q;
        if (rise) begin
            counter_d = 32'd1;
        end else if (busy && busy_q && (counter_q != 32'hFFFF_FFFF)) begin
            counter_d = counter_q + 32'd1;
        end
        if (fall) begin
            winner_d = winner_id;
            score_d  = max_score;
            cycles_d = counter_q;
            done_d   = 1'b1;
        end else if (clr_done) begin
            done_d = 1'b0;
        end
    end

    // Tracker state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            counter_q <= 32'd0;
            done_q    <= 1'b0;
            winner_q  <= 8'd0;
            score_q   <= 32'd0;
            cycles_q  <= 32'd0;
        end else begin
            busy_q    <= busy_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            winner_q  <= winner_d;
            score_q   <= score_d;
            cycles_q  <= cycles_d;
        end
    end

    assign done      = done_q;
    assign winner_sh = winner_q;
    assign score_sh  = score_q;
    assign cycles_sh = cycles_q;

endmodule

// File: rtl/vector_k_axi_rd.sv
// AXI4-Lite read responder for the vector-search core: status/result registers
// plus a 64-bit vector RAM readback window, one read outstanding at a time.
module vector_k_axi_rd
    import vk_axi_pkg::*;
#(
    parameter int MEM_AW     = 10,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic [31:0]       s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [63:0]       mem_rd_data,
    input  logic              busy,
    input  logic [7:0]        winner_id,
    input  logic [31:0]       max_score
);

    localparam logic [1:0] WAIT_INIT = 2'(MEM_RD_LAT - 1);

    logic [1:0]        state_q,    state_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [1:0]        rresp_q,    rresp_d;
    logic              half_q,     half_d;
    logic [1:0]        wait_q,     wait_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    logic              ar_hs;
    dec_e              dec;
    logic [MEM_AW-1:0] mem_idx;
    logic              done;
    logic [7:0]        winner_sh;
    logic [31:0]       score_sh;
    logic [31:0]       cycles_sh;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_araddr[31:16], s_axi_araddr[1:0]};

    assign dec     = decode_addr(s_axi_araddr[15:0]);
    assign ar_hs   = (state_q == ST_IDLE) && s_axi_arvalid;
    assign mem_idx = s_axi_araddr[MEM_AW+2:3];

    // RAM strobe is issued in the handshake cycle itself so data lands MEM_RD_LAT cycles later
    assign mem_rd_en   = ar_hs && (dec == DEC_MEM);
    assign mem_rd_addr = mem_rd_en ? mem_idx : mem_addr_q;

    assign s_axi_arready = (state_q == ST_IDLE);
    assign s_axi_rvalid  = (state_q == ST_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    vk_search_tracker u_tracker (
        .clk       (s_axi_aclk),
        .rst       (s_axi_areset),
        .busy      (busy),
        .winner_id (winner_id),
        .max_score (max_score),
        .clr_done  (ar_hs && (dec == DEC_STATUS)),
        .done      (done),
        .winner_sh (winner_sh),
        .score_sh  (score_sh),
        .cycles_sh (cycles_sh)
    );

    // Read FSM: decode on handshake, wait out RAM latency, hold response until rready
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        half_d     = half_q;
        wait_d     = wait_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    if (dec == DEC_MEM) begin
                        state_d    = ST_MEM_WAIT;
                        half_d     = s_axi_araddr[2];
                        wait_d     = WAIT_INIT;
                        mem_addr_d = mem_idx;
                    end else begin
                        state_d = ST_RESP;
                        rresp_d = RESP_OKAY;
                        case (dec)
                            DEC_STATUS: rdata_d = {30'b0, done, busy};
                            DEC_WINNER: rdata_d = {24'b0, winner_sh};
                            DEC_SCORE:  rdata_d = score_sh;
                            DEC_CYCLES: rdata_d = cycles_sh;
                            default: begin
                                rdata_d = 32'd0;
                                rresp_d = RESP_SLVERR;
                            end
                        endcase
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (wait_q == 2'd0) begin
                    rdata_d = half_q ? mem_rd_data[63:32] : mem_rd_data[31:0];
                    rresp_d = RESP_OKAY;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_RESP: begin
                if (s_axi_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and response registers
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q    <= ST_IDLE;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            half_q     <= 1'b0;
            wait_q     <= 2'd0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            half_q     <= half_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_vector_k_axi_rd.sv
// Self-checking bench for vector_k_axi_rd: directed vector table, multi-cycle
// corner sequences and randomized reads against a behavioural model.
module tb_vector_k_axi_rd;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_areset;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        busy;
    logic [7:0]  winner_id;
    logic [31:0] max_score;

    logic [63:0] ram [1024];

    int n_pass = 0;
    int n_total = 0;

    // Results of the most recent applyStimulus call
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    int          rd_lat;
    logic        rd_arready;
    logic        rd_en_seen;
    logic [9:0]  rd_idx_seen;

    // Behavioural model of the search result registers
    logic        m_done;
    logic [7:0]  m_win;
    logic [31:0] m_score;
    logic [31:0] m_cycles;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    vector_k_axi_rd #(.MEM_AW(10), .MEM_RD_LAT(1)) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .busy          (busy),
        .winner_id     (winner_id),
        .max_score     (max_score)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Vector RAM model with one cycle of read latency
    always @(posedge s_axi_aclk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One complete AR/R transaction; optionally drops busy on the handshake
    // cycle and optionally stalls rready while probing for stability
    task automatic applyStimulus(input logic [31:0] addr, input bit drop_busy,
                                 input int hold, input logic [31:0] hold_exp);
        int n;
        @(negedge s_axi_aclk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        if (drop_busy) busy = 1'b0;
        #1;
        rd_arready  = s_axi_arready;
        rd_en_seen  = mem_rd_en;
        rd_idx_seen = mem_rd_addr;
        @(posedge s_axi_aclk);
        #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        do begin
            @(negedge s_axi_aclk);
            n++;
        end while (!s_axi_rvalid && n < 16);
        rd_lat = n;
        if (!s_axi_rvalid) begin
            checkOutput("rvalid_timeout", 32'(s_axi_rvalid), 32'd1);
            return;
        end
        rd_data = s_axi_rdata;
        rd_resp = s_axi_rresp;
        if (hold > 0) begin
            s_axi_araddr  = 32'h0000_2008;
            s_axi_arvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                #1;
                checkOutput("hold_arready", 32'(s_axi_arready), 32'd0);
                checkOutput("hold_mem_rd_en", 32'(mem_rd_en), 32'd0);
                @(negedge s_axi_aclk);
                checkOutput("hold_rvalid", 32'(s_axi_rvalid), 32'd1);
                checkOutput("hold_rdata", s_axi_rdata, hold_exp);
            end
            s_axi_arvalid = 1'b0;
        end
        s_axi_rready = 1'b1;
        @(posedge s_axi_aclk);
        #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp_d,
                              input logic [1:0] exp_r, input int exp_lat);
        applyStimulus(addr, 1'b0, 0, 32'd0);
        checkOutput({name, "_data"}, rd_data, exp_d);
        checkOutput({name, "_resp"}, 32'(rd_resp), 32'(exp_r));
        checkOutput({name, "_lat"}, 32'(rd_lat), 32'(exp_lat));
        checkOutput({name, "_arready"}, 32'(rd_arready), 32'd1);
        if (exp_lat == 2) begin
            checkOutput({name, "_rd_en"}, 32'(rd_en_seen), 32'd1);
            checkOutput({name, "_rd_idx"}, 32'(rd_idx_seen), (addr & 32'hFFFF) / 8 - 32'h400);
        end
    endtask

    // Holds busy for len sampled cycles and then releases it
    task automatic do_search(input int len, input logic [7:0] id, input logic [31:0] sc);
        @(negedge s_axi_aclk);
        busy = 1'b1;
        winner_id = id;
        max_score = sc;
        repeat (len) @(negedge s_axi_aclk);
        busy = 1'b0;
    endtask

    // Expected response for an address given the model state; STATUS reads clear done
    function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                       output logic [1:0] r, output int lat);
        int unsigned off;
        logic [63:0] word;
        off = a & 32'hFFFF;
        d = 32'd0;
        r = 2'b00;
        lat = 1;
        if (off >= 32'h2000 && off < 32'h4000) begin
            word = ram[(off - 32'h2000) / 8];
            d = ((off / 4) % 2 == 1) ? word[63:32] : word[31:0];
            lat = 2;
        end else if (off == 0) begin
            d = {30'd0, m_done, 1'b0};
            m_done = 1'b0;
        end else if (off == 4) d = {24'd0, m_win};
        else if (off == 8) d = m_score;
        else if (off == 12) d = m_cycles;
        else r = 2'b10;
    endfunction

    initial begin
        logic [31:0] a, r32, ed;
        logic [1:0] er;
        int el, len;

        s_axi_areset  = 1'b1;
        s_axi_araddr  = 32'd0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        busy          = 1'b0;
        winner_id     = 8'd0;
        max_score     = 32'd0;
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        ram[7] = 64'hDEAD_BEEF_CAFE_F00D;

        repeat (3) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        #1;
        checkOutput("rst_arready", 32'(s_axi_arready), 32'd1);
        checkOutput("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        checkOutput("rst_rdata", s_axi_rdata, 32'd0);
        checkOutput("rst_rresp", 32'(s_axi_rresp), 32'd0);
        checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("rst_mem_rd_addr", 32'(mem_rd_addr), 32'd0);

        do_search(5, 8'h2A, 32'h1234);

        vecs.push_back('{32'h0000_0004, 32'h0000_002A, 2'b00, 1});
        vecs.push_back('{32'h0000_0008, 32'h0000_1234, 2'b00, 1});
        vecs.push_back('{32'h0000_000C, 32'd5,         2'b00, 1});
        vecs.push_back('{32'h0000_0000, 32'h2,         2'b00, 1});
        vecs.push_back('{32'h0000_0000, 32'h0,         2'b00, 1});
        vecs.push_back('{32'h0000_2038, 32'hCAFE_F00D, 2'b00, 2});
        vecs.push_back('{32'h0000_203C, 32'hDEAD_BEEF, 2'b00, 2});
        vecs.push_back('{32'h0000_0040, 32'h0,         2'b10, 1});
        vecs.push_back('{32'h0000_0004, 32'h0000_002A, 2'b00, 1});
        vecs.push_back('{32'h0000_4000, 32'h0,         2'b10, 1});
        vecs.push_back('{32'h0000_0002, 32'h0,         2'b10, 1});
        vecs.push_back('{32'hABCD_0008, 32'h0000_1234, 2'b00, 1});
        vecs.push_back('{32'h5555_3FFF, ram[1023][63:32], 2'b00, 2});
        vecs.push_back('{32'h0000_2001, ram[0][31:0], 2'b00, 2});

        foreach (vecs[i]) begin
            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].lat);
        end

        // Stalled response: data and ready must hold while rready stays low
        applyStimulus(32'h0000_0008, 1'b0, 4, 32'h0000_1234);
        checkOutput("hold_final_data", rd_data, 32'h0000_1234);
        read_check("after_hold", 32'h0000_000C, 32'd5, 2'b00, 1);

        // Live busy, then busy falling on the STATUS handshake cycle
        @(negedge s_axi_aclk);
        busy = 1'b1;
        winner_id = 8'h11;
        max_score = 32'h99;
        read_check("status_busy", 32'h0, 32'h1, 2'b00, 1);
        applyStimulus(32'h0, 1'b1, 0, 32'd0);
        checkOutput("same_cycle_status", rd_data, 32'h0);
        read_check("same_cycle_next", 32'h0, 32'h2, 2'b00, 1);
        read_check("same_cycle_winner", 32'h4, 32'h11, 2'b00, 1);

        // Reset while a response is pending
        do_search(3, 8'h55, 32'h77);
        @(negedge s_axi_aclk);
        s_axi_araddr  = 32'h0;
        s_axi_arvalid = 1'b1;
        @(posedge s_axi_aclk);
        #1;
        s_axi_arvalid = 1'b0;
        @(negedge s_axi_aclk);
        checkOutput("midrst_rvalid_pre", 32'(s_axi_rvalid), 32'd1);
        s_axi_areset = 1'b1;
        #1;
        checkOutput("midrst_rvalid", 32'(s_axi_rvalid), 32'd0);
        checkOutput("midrst_arready", 32'(s_axi_arready), 32'd1);
        @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        read_check("post_rst_status", 32'h0, 32'h0, 2'b00, 1);
        read_check("post_rst_winner", 32'h4, 32'h0, 2'b00, 1);

        // Randomized searches and reads against the model
        m_done = 1'b0;
        m_win = 8'd0;
        m_score = 32'd0;
        m_cycles = 32'd0;
        for (int it = 0; it < 80; it++) begin
            r32 = $urandom;
            case ($urandom % 4)
                0: begin
                    len = 1 + int'($urandom % 20);
                    a = $urandom;
                    do_search(len, a[7:0], r32);
                    m_done = 1'b1;
                    m_win = a[7:0];
                    m_score = r32;
                    m_cycles = 32'(len);
                end
                1: a = {r32[31:16], 16'(4 * ($urandom % 5))};
                2: a = {r32[31:16], 3'b001, r32[12:0]};
                default: a = r32;
            endcase
            if (busy == 1'b0 && r32 != 32'd0) begin
                model_read(a, ed, er, el);
                read_check($sformatf("rand%0d", it), a, ed, er, el);
            end
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
